// File: rtl/regfile_multiport.sv
// regfile_multiport: parametrised architectural register file with N read ports,
// optional write-to-read bypass, asynchronous clear and a per-register busy scoreboard.
//   clk, rst          : rising-edge clock, asynchronous active-high clear
//   rd_addr/rd_data   : NUM_RD combinational read ports (packed, port i at [i*W +: W])
//   rd_busy           : per-port "register has a pending producer" flag
//   we/wa/wd          : write-back port, also releases the register's reservation
//   rsv_en/rsv_addr   : decode-side reservation (marks register busy)
//   busy_cnt          : registered count of busy registers
module regfile_multiport #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned BYPASS   = 1,
  localparam int unsigned AW      = $clog2(NUM_REGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_RD*AW-1:0]   rd_addr,
  output logic [NUM_RD*XLEN-1:0] rd_data,
  output logic [NUM_RD-1:0]      rd_busy,
  input  logic                   we,
  input  logic [AW-1:0]          wa,
  input  logic [XLEN-1:0]        wd,
  input  logic                   rsv_en,
  input  logic [AW-1:0]          rsv_addr,
  output logic [AW:0]            busy_cnt
);

  localparam int unsigned CW = AW + 1;

  logic [XLEN-1:0]     regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;
  logic [CW-1:0]       cnt_nxt;
  logic                wr_ok;
  logic                rsv_ok;

  assign wr_ok  = we && (wa != '0);
  assign rsv_ok = rsv_en && (rsv_addr != '0);

  // Data storage; register 0 is never written and always reads as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[wa] <= wd;
    end
  end

  // Scoreboard next state: write-back releases, reservation sets and wins a tie.
  always_comb begin
    busy_nxt = busy;
    if (wr_ok)  busy_nxt[wa]       = 1'b0;
    if (rsv_ok) busy_nxt[rsv_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
    cnt_nxt = '0;
    for (int i = 1; i < NUM_REGS; i++) cnt_nxt = cnt_nxt + CW'(busy_nxt[i]);
  end

  // Busy bits and their population count move together on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

  // Combinational read ports; a matching write in flight is forwarded and
  // hides the busy flag since its producer is completing this cycle.
  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [AW-1:0] ra;
    logic          fwd;
    assign ra  = rd_addr[g*AW +: AW];
    assign fwd = (BYPASS != 0) && wr_ok && (wa == ra);
    assign rd_data[g*XLEN +: XLEN] = fwd ? wd : ((ra == '0) ? '0 : regs[ra]);
    assign rd_busy[g]              = fwd ? 1'b0 : busy[ra];
  end

endmodule

// File: tb/tb_regfile_multiport.sv
module tb_regfile_multiport;

  logic         clk;
  logic         rst;
  logic         we;
  logic         rsv_en;
  logic [4:0]   wa;
  logic [4:0]   rsv_addr;
  logic [31:0]  wd;
  logic [19:0]  rd_addr;
  logic [127:0] rdd_b, rdd_n;
  logic [3:0]   rdb_b, rdb_n;
  logic [5:0]   cnt_b, cnt_n;

  int checks = 0;
  int errors = 0;

  logic [31:0] mreg  [32];
  bit          mbusy [32];

  regfile_multiport #(.XLEN(32), .NUM_REGS(32), .NUM_RD(4), .BYPASS(1)) dut_b (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rdd_b), .rd_busy(rdb_b),
    .we(we), .wa(wa), .wd(wd), .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_cnt(cnt_b));

  regfile_multiport #(.XLEN(32), .NUM_REGS(32), .NUM_RD(4), .BYPASS(0)) dut_n (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rdd_n), .rd_busy(rdb_n),
    .we(we), .wa(wa), .wd(wd), .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_cnt(cnt_n));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      mreg[i]  = '0;
      mbusy[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    if (we && wa != 0) begin
      mreg[wa]  = wd;
      mbusy[wa] = 1'b0;
    end
    if (rsv_en && rsv_addr != 0) mbusy[rsv_addr] = 1'b1;
  endtask

  function automatic int mcount();
    int n = 0;
    for (int i = 1; i < 32; i++) n += int'(mbusy[i]);
    return n;
  endfunction

  function automatic bit fwd_hit(input int a, input bit byp);
    return byp && we && (int'(wa) == a) && (a != 0);
  endfunction

  function automatic logic [31:0] exp_data(input int a, input bit byp);
    if (fwd_hit(a, byp)) return wd;
    if (a == 0) return 32'h0;
    return mreg[a];
  endfunction

  function automatic logic exp_busy(input int a, input bit byp);
    if (fwd_hit(a, byp)) return 1'b0;
    if (a == 0) return 1'b0;
    return mbusy[a];
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    we = 1'b0; wa = '0; wd = '0; rsv_en = 1'b0; rsv_addr = '0;
  endtask

  task automatic set_rd(input int p, input logic [4:0] a);
    rd_addr[p*5 +: 5] = a;
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) model_edge();
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    idle();
    model_clear();
    rd_addr = 20'({5'd31, 5'd17, 5'd3, 5'd1});
    #7;
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (rdd_b[p*32 +: 32] !== 32'h0 || rdd_n[p*32 +: 32] !== 32'h0) begin
        errors++;
        $display("FAIL reset_data port%0d got %h/%h exp 0", p, rdd_b[p*32 +: 32], rdd_n[p*32 +: 32]);
      end
    end
    checks++;
    if (rdb_b !== 4'h0 || rdb_n !== 4'h0 || cnt_b !== 6'd0 || cnt_n !== 6'd0) begin
      errors++;
      $display("FAIL reset_busy got busy %h/%h cnt %0d/%0d exp 0", rdb_b, rdb_n, cnt_b, cnt_n);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic test_write_read();
    we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
    step();
    idle();
    set_rd(0, 5'd5);
    #1;
    checks++;
    if (rdd_b[31:0] !== 32'hDEADBEEF || rdd_n[31:0] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wr_rd_x5 got %h/%h exp deadbeef", rdd_b[31:0], rdd_n[31:0]);
    end
    we = 1'b1; wa = 5'd0; wd = 32'h1234;
    set_rd(0, 5'd0);
    #1;
    checks++;
    if (rdd_b[31:0] !== 32'h0 || rdb_b[0] !== 1'b0) begin
      errors++;
      $display("FAIL x0_no_bypass got %h busy %b exp 0 busy 0", rdd_b[31:0], rdb_b[0]);
    end
    step();
    idle();
    #1;
    checks++;
    if (rdd_b[31:0] !== 32'h0 || rdd_n[31:0] !== 32'h0 || rdb_b[0] !== 1'b0 || rdb_n[0] !== 1'b0) begin
      errors++;
      $display("FAIL x0_read got %h/%h busy %b/%b exp 0", rdd_b[31:0], rdd_n[31:0], rdb_b[0], rdb_n[0]);
    end
  endtask

  task automatic test_bypass();
    we = 1'b1; wa = 5'd7; wd = 32'h11;
    step();
    we = 1'b1; wa = 5'd7; wd = 32'h22;
    set_rd(1, 5'd7);
    #1;
    checks++;
    if (rdd_b[63:32] !== 32'h22) begin
      errors++;
      $display("FAIL bypass_on got %h exp 22", rdd_b[63:32]);
    end
    checks++;
    if (rdd_n[63:32] !== 32'h11) begin
      errors++;
      $display("FAIL bypass_off_before got %h exp 11", rdd_n[63:32]);
    end
    step();
    idle();
    #1;
    checks++;
    if (rdd_n[63:32] !== 32'h22 || rdd_b[63:32] !== 32'h22) begin
      errors++;
      $display("FAIL bypass_after got %h/%h exp 22", rdd_b[63:32], rdd_n[63:32]);
    end
  endtask

  task automatic test_scoreboard();
    set_rd(0, 5'd3);
    rsv_en = 1'b1; rsv_addr = 5'd3;
    step();
    idle();
    #1;
    checks++;
    if (rdb_n[0] !== 1'b1 || rdb_b[0] !== 1'b1 || cnt_b !== 6'd1 || cnt_n !== 6'd1) begin
      errors++;
      $display("FAIL rsv_x3 got busy %b/%b cnt %0d/%0d exp 1 cnt 1", rdb_b[0], rdb_n[0], cnt_b, cnt_n);
    end
    we = 1'b1; wa = 5'd3; wd = 32'h55;
    #1;
    checks++;
    if (rdb_b[0] !== 1'b0 || rdb_n[0] !== 1'b1) begin
      errors++;
      $display("FAIL busy_fwd_mask got %b/%b exp 0/1", rdb_b[0], rdb_n[0]);
    end
    step();
    idle();
    #1;
    checks++;
    if (rdb_b[0] !== 1'b0 || rdb_n[0] !== 1'b0 || cnt_b !== 6'd0 || cnt_n !== 6'd0) begin
      errors++;
      $display("FAIL release_x3 got busy %b/%b cnt %0d/%0d exp 0", rdb_b[0], rdb_n[0], cnt_b, cnt_n);
    end
    we = 1'b1; wa = 5'd3; wd = 32'h55;
    rsv_en = 1'b1; rsv_addr = 5'd3;
    step();
    idle();
    #1;
    checks++;
    if (rdb_b[0] !== 1'b1 || rdb_n[0] !== 1'b1 || cnt_b !== 6'd1 || rdd_b[31:0] !== 32'h55 || rdd_n[31:0] !== 32'h55) begin
      errors++;
      $display("FAIL rsv_wins got busy %b/%b cnt %0d data %h/%h exp 1 cnt 1 data 55",
               rdb_b[0], rdb_n[0], cnt_b, rdd_b[31:0], rdd_n[31:0]);
    end
  endtask

  task automatic test_multi_port();
    we = 1'b1; wa = 5'd9; wd = 32'hA5A5A5A5;
    step();
    idle();
    for (int p = 0; p < 4; p++) set_rd(p, 5'd9);
    #1;
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (rdd_b[p*32 +: 32] !== 32'hA5A5A5A5 || rdd_n[p*32 +: 32] !== 32'hA5A5A5A5) begin
        errors++;
        $display("FAIL same_reg port%0d got %h/%h exp a5a5a5a5", p, rdd_b[p*32 +: 32], rdd_n[p*32 +: 32]);
      end
    end
  endtask

  task automatic test_busy_fill();
    for (int r = 1; r < 32; r++) begin
      rsv_en = 1'b1; rsv_addr = 5'(r);
      step();
    end
    idle();
    #1;
    checks++;
    if (cnt_b !== 6'd31 || cnt_n !== 6'd31) begin
      errors++;
      $display("FAIL fill_cnt got %0d/%0d exp 31", cnt_b, cnt_n);
    end
    rsv_en = 1'b1; rsv_addr = 5'd0;
    step();
    idle();
    #1;
    checks++;
    if (cnt_b !== 6'd31 || cnt_n !== 6'd31) begin
      errors++;
      $display("FAIL rsv_x0_cnt got %0d/%0d exp 31", cnt_b, cnt_n);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      we       = ($urandom_range(0, 99) < 60);
      wa       = 5'($urandom_range(0, 31));
      wd       = $urandom;
      rsv_en   = ($urandom_range(0, 99) < 45);
      rsv_addr = ($urandom_range(0, 4) == 0) ? wa : 5'($urandom_range(0, 31));
      for (int p = 0; p < 4; p++)
        set_rd(p, ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31)));
      #1;
      for (int p = 0; p < 4; p++) begin
        int a;
        a = int'(rd_addr[p*5 +: 5]);
        checks++;
        if (rdd_b[p*32 +: 32] !== exp_data(a, 1'b1) || rdb_b[p] !== exp_busy(a, 1'b1)) begin
          errors++;
          $display("FAIL rand_byp port%0d addr %0d got %h/%b exp %h/%b", p, a,
                   rdd_b[p*32 +: 32], rdb_b[p], exp_data(a, 1'b1), exp_busy(a, 1'b1));
        end
        checks++;
        if (rdd_n[p*32 +: 32] !== exp_data(a, 1'b0) || rdb_n[p] !== exp_busy(a, 1'b0)) begin
          errors++;
          $display("FAIL rand_nobyp port%0d addr %0d got %h/%b exp %h/%b", p, a,
                   rdd_n[p*32 +: 32], rdb_n[p], exp_data(a, 1'b0), exp_busy(a, 1'b0));
        end
      end
      checks++;
      if (int'(cnt_b) != mcount() || int'(cnt_n) != mcount()) begin
        errors++;
        $display("FAIL rand_cnt got %0d/%0d exp %0d", cnt_b, cnt_n, mcount());
      end
      step();
    end
    idle();
  endtask

  task automatic test_async_reset();
    for (int r = 1; r < 32; r++) begin
      we = 1'b1; wa = 5'(r); wd = 32'h1000 + 32'(r);
      step();
    end
    idle();
    rsv_en = 1'b1; rsv_addr = 5'd4;
    step();
    idle();
    rd_addr = 20'({5'd31, 5'd6, 5'd4, 5'd1});
    #1;
    checks++;
    if (rdb_b[1] !== 1'b1 || rdd_b[31:0] !== 32'h1001) begin
      errors++;
      $display("FAIL pre_reset got busy %b data %h exp 1 1001", rdb_b[1], rdd_b[31:0]);
    end
    #1;
    rst = 1'b1;
    model_clear();
    we = 1'b1; wa = 5'd10; wd = 32'hBAD0BAD0;
    rsv_en = 1'b1; rsv_addr = 5'd12;
    #1;
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < 4; p++) begin
        checks++;
        if (rdd_b[p*32 +: 32] !== 32'h0 || rdd_n[p*32 +: 32] !== 32'h0) begin
          errors++;
          $display("FAIL async_rst%0d port%0d got %h/%h exp 0", k, p, rdd_b[p*32 +: 32], rdd_n[p*32 +: 32]);
        end
      end
      checks++;
      if (rdb_b !== 4'h0 || rdb_n !== 4'h0 || cnt_b !== 6'd0 || cnt_n !== 6'd0) begin
        errors++;
        $display("FAIL async_rst%0d busy got %h/%h cnt %0d/%0d exp 0", k, rdb_b, rdb_n, cnt_b, cnt_n);
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    rst = 1'b0;
    idle();
    set_rd(0, 5'd10);
    set_rd(1, 5'd12);
    #1;
    checks++;
    if (rdd_b[31:0] !== 32'h0 || rdd_n[31:0] !== 32'h0 || rdb_b[1] !== 1'b0 || rdb_n[1] !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_commit got %h/%h busy %b/%b exp 0", rdd_b[31:0], rdd_n[31:0], rdb_b[1], rdb_n[1]);
    end
    we = 1'b1; wa = 5'd10; wd = 32'h77;
    step();
    idle();
    #1;
    checks++;
    if (rdd_b[31:0] !== 32'h77 || rdd_n[31:0] !== 32'h77 || cnt_b !== 6'd0) begin
      errors++;
      $display("FAIL post_rst_write got %h/%h cnt %0d exp 77 cnt 0", rdd_b[31:0], rdd_n[31:0], cnt_b);
    end
  endtask

  initial begin
    rd_addr = '0;
    test_reset();
    test_write_read();
    test_bypass();
    test_scoreboard();
    test_multi_port();
    test_busy_fill();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
